// File: rtl/window_generator.sv
// Sliding 3x3 window generator: two row-delay line buffers feed a shifting 3x3
// tap array; a window is emitted only when all nine taps lie inside the current frame.
module window_generator #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_valid,
  output logic [71:0] window,
  output logic        window_valid,
  output logic        frame_done
);

  localparam int ColW = $clog2(IMG_WIDTH);
  localparam int RowW = $clog2(IMG_HEIGHT);
  localparam logic [ColW-1:0] LastCol = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(IMG_HEIGHT - 1);

  logic [ColW-1:0] col;
  logic [RowW-1:0] row;

  // lineBuf1[c] holds P(R-1,c) and lineBuf2[c] holds P(R-2,c) until column c is revisited.
  logic [7:0]  lineBuf1 [IMG_WIDTH];
  logic [7:0]  lineBuf2 [IMG_WIDTH];
  logic [7:0]  taps     [3][3];
  logic [7:0]  tapsNext [3][3];
  logic [71:0] windowNext;

  logic accept;
  logic lastCol;
  logic lastRow;
  logic fullWindow;

  assign accept     = pixel_valid && !rst;
  assign lastCol    = (col == LastCol);
  assign lastRow    = (row == LastRow);
  assign fullWindow = (row >= RowW'(2)) && (col >= ColW'(2));

  always_comb begin
    // NOTE: every variable driven here is assigned unconditionally before use, so no latch is inferred.
    windowNext = '0;
    for (int r = 0; r < 3; r++) begin
      tapsNext[r][0] = taps[r][1];
      tapsNext[r][1] = taps[r][2];
    end
    tapsNext[0][2] = lineBuf2[col];
    tapsNext[1][2] = lineBuf1[col];
    tapsNext[2][2] = pixel_in;
    // Row-major packing, oldest row and column in the most significant byte.
    for (int k = 0; k < 9; k++) begin
      windowNext[71 - 8*k -: 8] = tapsNext[k / 3][k % 3];
    end
  end

  // NOTE: buffer and tap storage carries no reset; the row/col gate keeps stale contents from ever reaching the output.
  always_ff @(posedge clk) begin
    if (accept) begin
      lineBuf2[col] <= lineBuf1[col];
      lineBuf1[col] <= pixel_in;
      taps          <= tapsNext;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      window       <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= pixel_valid && fullWindow;
      frame_done   <= pixel_valid && lastCol && lastRow;
      if (pixel_valid && fullWindow) begin
        window <= windowNext;
      end
      if (pixel_valid) begin
        if (lastCol) begin
          col <= '0;
          row <= lastRow ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_generator.sv
// Self-checking bench: a 4x4 and a default 8x8 instance are compared every cycle
// against a frame-image reference model driven by directed and random streams.
module tb_window_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pixelIn;
  logic        pixelValid;
  bit          useBig;
  logic        valid4, valid8;
  logic [71:0] win4, win8;
  logic        wv4, wv8, fd4, fd8;

  always #5 clk = ~clk;

  assign valid4 = pixelValid && !useBig;
  assign valid8 = pixelValid && useBig;

  window_generator #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .pixel_in(pixelIn), .pixel_valid(valid4),
    .window(win4), .window_valid(wv4), .frame_done(fd4)
  );

  window_generator dut8 (
    .clk(clk), .rst(rst), .pixel_in(pixelIn), .pixel_valid(valid8),
    .window(win8), .window_valid(wv8), .frame_done(fd8)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: the frame as an image plus the current raster position.
  logic [7:0]  img [8][8];
  int          imgW, imgH, mRow, mCol;
  logic [71:0] expWin;
  logic        expValid, expDone;
  int          obsPulses;
  logic [71:0] obsWins [$];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearObs();
    obsPulses = 0;
    obsWins.delete();
  endtask

  task automatic step(input bit pv, input logic [7:0] px, input bit doRst);
    logic [71:0] oWin;
    logic        oValid, oDone;
    rst        = doRst;
    pixelValid = pv;
    pixelIn    = px;
    @(posedge clk);
    expValid = 1'b0;
    expDone  = 1'b0;
    if (doRst) begin
      mRow   = 0;
      mCol   = 0;
      expWin = '0;
    end else if (pv) begin
      img[mRow][mCol] = px;
      if (mRow >= 2 && mCol >= 2) begin
        expValid = 1'b1;
        for (int k = 0; k < 9; k++)
          expWin[71 - 8*k -: 8] = img[mRow - 2 + k / 3][mCol - 2 + k % 3];
      end
      expDone = (mRow == imgH - 1) && (mCol == imgW - 1);
      mCol++;
      if (mCol == imgW) begin
        mCol = 0;
        mRow = (mRow + 1) % imgH;
      end
    end
    #1;
    oWin   = useBig ? win8 : win4;
    oValid = useBig ? wv8 : wv4;
    oDone  = useBig ? fd8 : fd4;
    check("window_valid", 72'(oValid), 72'(expValid));
    check("frame_done", 72'(oDone), 72'(expDone));
    check("window", oWin, expWin);
    if (oValid === 1'b1) begin
      obsPulses++;
      obsWins.push_back(oWin);
    end
  endtask

  task automatic resetFor(input int n);
    repeat (n) step(1'b1, 8'($urandom), 1'b1);
    clearObs();
  endtask

  // gapMode: 0 gapless, 1 one idle cycle after each pixel, 2 random idle runs.
  task automatic sendPixels(input int n, input int base, input int gapMode, input bit randData);
    for (int idx = 0; idx < n; idx++) begin
      if (gapMode == 2)
        while ($urandom_range(0, 2) == 0) step(1'b0, 8'($urandom), 1'b0);
      step(1'b1, randData ? 8'($urandom) : 8'(base + idx), 1'b0);
      if (gapMode == 1) step(1'b0, 8'($urandom), 1'b0);
    end
  endtask

  task automatic checkSmallFrame(input string tag);
    check({tag, "_pulses"}, 72'(obsPulses), 72'd4);
    if (obsWins.size() == 4) begin
      check({tag, "_first"}, obsWins[0], 72'h01_02_03_05_06_07_09_0A_0B);
      check({tag, "_last"},  obsWins[3], 72'h06_07_08_0A_0B_0C_0E_0F_10);
    end
  endtask

  initial begin
    useBig     = 1'b0;
    imgW       = 4;
    imgH       = 4;
    rst        = 1'b1;
    pixelValid = 1'b0;
    pixelIn    = '0;
    clearObs();

    // Reset held with pixel_valid high: outputs must stay zero, pixels discarded.
    resetFor(3);

    sendPixels(16, 1, 0, 1'b0);
    checkSmallFrame("gapless");

    clearObs();
    sendPixels(16, 1, 1, 1'b0);
    checkSmallFrame("toggled");

    clearObs();
    sendPixels(16, 1, 0, 1'b0);
    sendPixels(16, 101, 0, 1'b0);
    check("b2b_pulses", 72'(obsPulses), 72'd8);
    if (obsWins.size() == 8)
      check("b2b_frame2_first", obsWins[4], 72'h65_66_67_69_6A_6B_6D_6E_6F);

    sendPixels(10, 200, 0, 1'b0);
    resetFor(1);
    sendPixels(16, 1, 0, 1'b0);
    checkSmallFrame("after_reset");

    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        sendPixels($urandom_range(1, 15), 0, 2, 1'b1);
        resetFor($urandom_range(1, 2));
      end
      sendPixels(16, 0, 2, 1'b1);
    end

    useBig = 1'b1;
    imgW   = 8;
    imgH   = 8;
    resetFor(2);
    sendPixels(64, 0, 2, 1'b0);
    check("big_pulses", 72'(obsPulses), 72'd36);
    if (obsWins.size() == 36)
      for (int k = 0; k < 36; k++)
        check("big_center", 72'(obsWins[k][39:32]), 72'(8 * (k / 6 + 1) + (k % 6 + 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
